dmx_tx_sequencer: RTL and testbench

- Frame scheduler for the DMX512 output path.
- Generates the frame sequence: break, mark-after-break (MAB), start-code slot, then NUM_SLOTS data slots (8N2, 250 kbaud).
- Fetches each channel byte from the synchronous channel RAM written by the tracking logic, and aligns the RAM's read latency with a parameterized delay line.
- Sits between the channel RAM and the RS-485 transmitter pin.

---
 rtl/dmx_tx_sequencer_pkg.sv | 34 +++
 rtl/dmx_tx_sequencer_delay_line.sv | 31 +++
 rtl/dmx_tx_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_dmx_tx_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmx_tx_sequencer_pkg.sv
`timescale 1ns/1ps
// Shared state encoding, frame constants and slot-count helper for the DMX512 transmit sequencer.
package dmx_tx_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BREAK = 2'd1,
        MAB   = 2'd2,
        SLOT  = 2'd3
    } state_t;

    localparam int DMX_BITS_PER_SLOT = 11;
    localparam int DMX_MAX_SLOTS     = 512;
    localparam int DMX_ADDR_W        = 9;
    localparam int DMX_SLOT_W        = 10;

    // Bit positions inside a slot: 0 = start, 1..8 = data LSB first, 9/10 = stop bits.
    localparam int DMX_STOP1_BIT = 9;
    localparam int DMX_STOP2_BIT = 10;

    function automatic logic [DMX_SLOT_W-1:0] clamp_slots(
        input logic [DMX_SLOT_W-1:0] req,
        input logic [DMX_SLOT_W-1:0] limit
    );
        if (req == '0) begin
            return DMX_SLOT_W'(1);
        end
        if (req > limit) begin
            return limit;
        end
        return req;
    endfunction

endpackage

// File: rtl/dmx_tx_sequencer_delay_line.sv
`timescale 1ns/1ps
// Parameterized shift-register delay line; output follows input NDELAY clock cycles later.
module dmx_tx_sequencer_delay_line #(
    parameter int NDELAY = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [NDELAY];

    // NOTE: every stage is reset so no stale strobe can fire a load after reset releases.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NDELAY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < NDELAY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[NDELAY-1];

endmodule

// File: rtl/dmx_tx_sequencer.sv
`timescale 1ns/1ps
// DMX512 frame scheduler: break, MAB, start code and channel slots fetched from the channel RAM.
// Optional per-frame slot limit input enabled by defining DMX_SLOT_LIMIT_EN.
module dmx_tx_sequencer
    import dmx_tx_sequencer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 108,
    parameter int BREAK_BITS   = 23,
    parameter int MAB_BITS     = 3,
    parameter int NUM_SLOTS    = 512,
    parameter int RAM_LATENCY  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [7:0]            start_code,
`ifdef DMX_SLOT_LIMIT_EN
    input  logic [9:0]            num_slots,
`endif
    output logic [DMX_ADDR_W-1:0] rd_addr,
    output logic                  rd_en,
    input  logic [7:0]            rd_data,
    output logic                  dmx_tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int MAX_BITS_A = (BREAK_BITS > MAB_BITS) ? BREAK_BITS : MAB_BITS;
    localparam int MAX_BITS   = (MAX_BITS_A > DMX_BITS_PER_SLOT) ? MAX_BITS_A : DMX_BITS_PER_SLOT;
    localparam int BIT_W      = $clog2(MAX_BITS);
    localparam int CLK_W      = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CLK_W-1:0]      CLK_LAST   = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]      BREAK_LAST = BIT_W'(BREAK_BITS - 1);
    localparam logic [BIT_W-1:0]      MAB_LAST   = BIT_W'(MAB_BITS - 1);
    localparam logic [BIT_W-1:0]      STOP1      = BIT_W'(DMX_STOP1_BIT);
    localparam logic [BIT_W-1:0]      STOP2      = BIT_W'(DMX_STOP2_BIT);
    localparam logic [DMX_SLOT_W-1:0] SLOT_MAX   = DMX_SLOT_W'(NUM_SLOTS);

    state_t                  state_q, state_n;
    logic [CLK_W-1:0]        clk_q, clk_n;
    logic [BIT_W-1:0]        bit_q, bit_n;
    logic [DMX_SLOT_W-1:0]   slot_q, slot_n;
    logic [DMX_SLOT_W-1:0]   last_q, last_n;
    logic [7:0]              shift_q, shift_n;
    logic [7:0]              hold_q;
    logic                    bit_tick;
    logic                    tx_n;
    logic                    done_n;
    logic                    rd_en_n;
    logic                    load;
    logic [2:0]              data_idx;

    assign bit_tick = (clk_q == CLK_LAST);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n = state_q;
        clk_n   = clk_q;
        bit_n   = bit_q;
        slot_n  = slot_q;
        last_n  = last_q;
        shift_n = shift_q;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_n = BREAK;
                    clk_n   = '0;
                    bit_n   = '0;
                    slot_n  = '0;
                end
            end

            BREAK: begin
                if (!bit_tick) begin
                    clk_n = clk_q + CLK_W'(1);
                end else begin
                    clk_n = '0;
                    if (bit_q == BREAK_LAST) begin
                        state_n = MAB;
                        bit_n   = '0;
                        shift_n = start_code;
`ifdef DMX_SLOT_LIMIT_EN
                        last_n  = clamp_slots(num_slots, SLOT_MAX);
`else
                        last_n  = SLOT_MAX;
`endif
                    end else begin
                        bit_n = bit_q + BIT_W'(1);
                    end
                end
            end

            MAB: begin
                if (!bit_tick) begin
                    clk_n = clk_q + CLK_W'(1);
                end else begin
                    clk_n = '0;
                    if (bit_q == MAB_LAST) begin
                        state_n = SLOT;
                        bit_n   = '0;
                        slot_n  = '0;
                    end else begin
                        bit_n = bit_q + BIT_W'(1);
                    end
                end
            end

            SLOT: begin
                if (!bit_tick) begin
                    clk_n = clk_q + CLK_W'(1);
                end else begin
                    clk_n = '0;
                    if (bit_q != STOP2) begin
                        bit_n = bit_q + BIT_W'(1);
                    end else if (slot_q == last_q) begin
                        // Enable is sampled only here, so a late rise still chains the next frame.
                        state_n = enable ? BREAK : IDLE;
                        bit_n   = '0;
                        slot_n  = '0;
                    end else begin
                        bit_n   = '0;
                        slot_n  = slot_q + DMX_SLOT_W'(1);
                        shift_n = hold_q;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Line level, strobes and done pulse are all derived from next-state values and then registered.
    assign data_idx = 3'(bit_n - BIT_W'(1));

    always_comb begin
        tx_n = 1'b1;
        unique case (state_n)
            BREAK:   tx_n = 1'b0;
            SLOT: begin
                if (bit_n == '0) begin
                    tx_n = 1'b0;
                end else if (bit_n < STOP1) begin
                    tx_n = shift_n[data_idx];
                end else begin
                    tx_n = 1'b1;
                end
            end
            default: tx_n = 1'b1;
        endcase
    end

    assign rd_en_n = (state_n == SLOT) && (bit_n == STOP1) && (clk_n == '0) && (slot_n < last_n);
    assign done_n  = (state_n == SLOT) && (bit_n == STOP2) && (clk_n == CLK_LAST)
                     && (slot_n == last_n);

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same snapshot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            clk_q      <= '0;
            bit_q      <= '0;
            slot_q     <= '0;
            last_q     <= '0;
            shift_q    <= '0;
            dmx_tx     <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
        end else begin
            state_q    <= state_n;
            clk_q      <= clk_n;
            bit_q      <= bit_n;
            slot_q     <= slot_n;
            last_q     <= last_n;
            shift_q    <= shift_n;
            dmx_tx     <= tx_n;
            busy       <= (state_n != IDLE);
            frame_done <= done_n;
            rd_en      <= rd_en_n;
            if (rd_en_n) begin
                rd_addr <= slot_n[DMX_ADDR_W-1:0];
            end
        end
    end

    // The read strobe is delayed by the RAM latency so the load lands on the cycle rd_data is valid.
    dmx_tx_sequencer_delay_line #(
        .NDELAY (RAM_LATENCY),
        .WIDTH  (1)
    ) u_rd_align (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (rd_en),
        .dout    (load)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= '0;
        end else if (load) begin
            hold_q <= rd_data;
        end
    end

endmodule

// File: tb/tb_dmx_tx_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for dmx_tx_sequencer: expected line waveform built from the DMX frame rules.
module tb_dmx_tx_sequencer;

    localparam int CPB    = 4;
    localparam int BRK    = 23;
    localparam int MABB   = 3;
    localparam int NS     = 4;
    localparam int LAT    = 2;
    localparam int HDR    = (BRK + MABB) * CPB;
    localparam int SLOT_T = 11 * CPB;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] start_code = 8'h00;
    logic [8:0] rd_addr;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       dmx_tx;
    logic       busy;
    logic       frame_done;
`ifdef DMX_SLOT_LIMIT_EN
    logic [9:0] num_slots = 10'(NS);
`endif

    logic [7:0] mem [NS];
    logic [7:0] ram_p1 = 8'hEE;
    logic [7:0] ram_p2 = 8'hEE;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Two-cycle synchronous RAM; data is only valid in the single cycle LAT after the strobe.
    always @(posedge clk) begin
        ram_p1 <= (rd_en && rd_addr < 9'(NS)) ? mem[rd_addr[1:0]] : 8'hEE;
        ram_p2 <= ram_p1;
    end
    assign rd_data = ram_p2;

    dmx_tx_sequencer #(
        .CLKS_PER_BIT (CPB),
        .BREAK_BITS   (BRK),
        .MAB_BITS     (MABB),
        .NUM_SLOTS    (NS),
        .RAM_LATENCY  (LAT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .start_code (start_code),
`ifdef DMX_SLOT_LIMIT_EN
        .num_slots  (num_slots),
`endif
        .rd_addr    (rd_addr),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .dmx_tx     (dmx_tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_check(input string tag, input int ncyc);
        int bad = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (dmx_tx !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0 || frame_done !== 1'b0) bad++;
        end
        check(tag, bad, 0);
    endtask

    task automatic randomize_mem();
        for (int k = 0; k < NS; k++) mem[k] = 8'($urandom);
    endtask

    // Caller sets enable=1 on a negedge (or leaves it high from the previous frame) just before this.
    task automatic run_frame(input string tag, input logic [7:0] sc, input logic [9:0] ns_req,
                             input logic en_hold, input int sw_at, input logic sw_val);
        int         ns_eff;
        int         total;
        logic       exp_tx[$];
        logic [7:0] bytes[$];
        logic       tx_cap[$];
        int         rd_idx[$];
        int         rd_adr[$];
        int         wave_err = 0;
        int         busy_err = 0;
        int         fd_cnt = 0;
        int         fd_idx = -1;
        logic [10:0] frame_bits;
        logic [7:0]  dec;
        int          nrd;

        ns_eff = (ns_req == 10'd0) ? 1 : ((int'(ns_req) > NS) ? NS : int'(ns_req));
        bytes.push_back(sc);
        for (int k = 0; k < ns_eff; k++) bytes.push_back(mem[k]);
        for (int i = 0; i < BRK * CPB; i++) exp_tx.push_back(1'b0);
        for (int i = 0; i < MABB * CPB; i++) exp_tx.push_back(1'b1);
        foreach (bytes[j]) begin
            frame_bits = {2'b11, bytes[j], 1'b0};
            for (int b = 0; b < 11; b++)
                for (int c = 0; c < CPB; c++) exp_tx.push_back(frame_bits[b]);
        end
        total = exp_tx.size();

        for (int i = 0; i < total; i++) begin
            @(negedge clk);
            tx_cap.push_back(dmx_tx);
            if (dmx_tx !== exp_tx[i]) wave_err++;
            if (busy !== 1'b1) busy_err++;
            if (frame_done === 1'b1) begin
                fd_cnt++;
                fd_idx = i;
            end
            if (rd_en === 1'b1) begin
                rd_idx.push_back(i);
                rd_adr.push_back(int'(rd_addr));
            end
            if (i == 0) begin
                enable     = en_hold;
                start_code = sc;
`ifdef DMX_SLOT_LIMIT_EN
                num_slots  = ns_req;
`endif
            end
            if (i == HDR) begin
                start_code = ~sc;
`ifdef DMX_SLOT_LIMIT_EN
                num_slots  = 10'($urandom);
`endif
            end
            if (i == sw_at) enable = sw_val;
        end

        check($sformatf("%s_wave_err", tag), wave_err, 0);
        check($sformatf("%s_busy_err", tag), busy_err, 0);
        check($sformatf("%s_done_count", tag), fd_cnt, 1);
        check($sformatf("%s_done_index", tag), fd_idx, total - 1);
        check($sformatf("%s_rd_count", tag), rd_idx.size(), ns_eff);
        nrd = (rd_idx.size() < ns_eff) ? rd_idx.size() : ns_eff;
        for (int k = 0; k < nrd; k++) begin
            check($sformatf("%s_rd%0d_cycle", tag, k), rd_idx[k], HDR + k * SLOT_T + 9 * CPB);
            check($sformatf("%s_rd%0d_addr", tag, k), rd_adr[k], k);
        end
        foreach (bytes[j]) begin
            for (int b = 0; b < 8; b++)
                dec[b] = tx_cap[HDR + j * SLOT_T + (b + 1) * CPB + CPB / 2];
            check($sformatf("%s_slot%0d", tag, j), dec, bytes[j]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sc;
        int         full;

        full = HDR + (NS + 1) * SLOT_T;
        for (int k = 0; k < NS; k++) mem[k] = 8'hA0 + 8'(k);

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_tx", dmx_tx, 1);
        check("reset_busy", busy, 0);
        check("reset_rd_en", rd_en, 0);
        check("reset_rd_addr", rd_addr, 0);
        check("reset_done", frame_done, 0);
        reset_n = 1'b1;
        idle_check("idle_after_reset", 30);

        // Single-cycle enable pulse, start code 00, default RAM contents
        enable = 1'b1;
        run_frame("pulse", 8'h00, 10'(NS), 1'b0, -1, 1'b0);
        idle_check("idle_after_pulse", 20);

        // Back-to-back frames, then enable dropped during slot 2
        enable = 1'b1;
        sc = 8'($urandom);
        run_frame("b2b_first", sc, 10'(NS), 1'b1, -1, 1'b0);
        sc = 8'($urandom);
        run_frame("b2b_drop", sc, 10'(NS), 1'b1, HDR + 2 * SLOT_T + 12, 1'b0);
        idle_check("idle_after_drop", 20);

        // Enable rising during the final stop bit still chains the next frame
        randomize_mem();
        enable = 1'b1;
        sc = 8'($urandom);
        run_frame("late_rise", sc, 10'(NS), 1'b0, full - 2, 1'b1);
        sc = 8'($urandom);
        run_frame("after_late", sc, 10'(NS), 1'b0, -1, 1'b0);
        idle_check("idle_after_late", 10);

        // Randomized gaps, RAM contents and start codes
        for (int r = 0; r < 2; r++) begin
            idle_check($sformatf("rand_gap%0d", r), int'($urandom_range(1, 20)));
            randomize_mem();
            enable = 1'b1;
            run_frame($sformatf("rand%0d", r), 8'($urandom), 10'(NS), 1'b0, -1, 1'b0);
        end

        // Asynchronous reset in the start bit of slot 1
        enable = 1'b1;
        for (int i = 0; i <= HDR + SLOT_T + 1; i++) begin
            @(negedge clk);
            if (i == 0) enable = 1'b0;
        end
        check("pre_reset_tx", dmx_tx, 0);
        #1 reset_n = 1'b0;
        #1;
        check("async_reset_tx", dmx_tx, 1);
        check("async_reset_busy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        idle_check("idle_after_async", 20);
        enable = 1'b1;
        run_frame("recover", 8'($urandom), 10'(NS), 1'b0, -1, 1'b0);
        idle_check("idle_after_recover", 10);

`ifdef DMX_SLOT_LIMIT_EN
        for (int k = 0; k < NS; k++) mem[k] = 8'hA0 + 8'(k);
        enable = 1'b1;
        run_frame("limit2", 8'($urandom), 10'd2, 1'b0, -1, 1'b0);
        idle_check("idle_after_limit2", 10);
        enable = 1'b1;
        run_frame("limit0", 8'($urandom), 10'd0, 1'b0, -1, 1'b0);
        idle_check("idle_after_limit0", 10);
        enable = 1'b1;
        run_frame("limit9", 8'($urandom), 10'd9, 1'b0, -1, 1'b0);
        idle_check("idle_after_limit9", 10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
